// File: rtl/key_matrix_scanner.sv
// Keyboard matrix scanner: drives one row at a time, samples the columns
// through a 2-flop synchroniser, debounces every key, and queues
// press/release events in a small FIFO with a valid/ready output.
module key_matrix_scanner #(
  parameter  int ROWS       = 8,
  parameter  int COLS       = 8,
  parameter  int DEBOUNCE   = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_tick,
  output logic [ROWS-1:0]  row_drive,
  input  logic [COLS-1:0]  col_sense,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_pressed,
  output logic [ROW_W-1:0] evt_row,
  output logic [COL_W-1:0] evt_col
);

  localparam int KEYS  = ROWS * COLS;
  localparam int KEY_W = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_DRIVE   = 2'd0;
  localparam logic [1:0] ST_SCAN    = 2'd1;
  localparam logic [1:0] ST_ADVANCE = 2'd2;

  typedef struct packed {
    logic             pressed;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } evt_t;

  // Synchroniser and scan sequencing
  logic [COLS-1:0]  r_sync1;
  logic [COLS-1:0]  r_sync2;
  logic [COLS-1:0]  r_col_latch;
  logic [1:0]       r_state;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [ROWS-1:0]  r_row_drive;

  // Per-key debounce state
  logic [KEYS-1:0]  r_stable;
  logic [CNT_W-1:0] r_cnt [KEYS];

  // Event queue
  evt_t             r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;

  logic [ROW_W-1:0] w_row_next;
  logic [KEY_W-1:0] w_key;
  logic             w_in_scan;
  logic             w_raw;
  logic             w_stable;
  logic [CNT_W-1:0] w_cnt;
  logic             w_differs;
  logic             w_cnt_full;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  evt_t             w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_row_next = (int'(r_row) == ROWS - 1) ? '0 : r_row + ROW_W'(1);
  assign w_key      = KEY_W'(int'(r_row) * COLS + int'(r_col));
  assign w_in_scan  = (r_state == ST_SCAN);
  assign w_raw      = ~r_col_latch[r_col];
  assign w_stable   = r_stable[w_key];
  assign w_cnt      = r_cnt[w_key];
  assign w_differs  = w_in_scan && (w_raw != w_stable);
  assign w_cnt_full = (int'(w_cnt) + 1 == DEBOUNCE);
  assign w_push     = w_differs && w_cnt_full;
  assign w_pop      = evt_valid && evt_ready;
  assign w_full     = (int'(r_occ) == FIFO_DEPTH);
  // A full queue still takes a push when the head leaves in the same cycle.
  assign w_push_ok  = w_push && (!w_full || w_pop);

  // Two-flop synchroniser for the asynchronous column lines (idle high)
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= col_sense;
      r_sync2 <= r_sync1;
    end
  end

  // Scan FSM: wait for tick, walk the columns of the latched row, advance row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_DRIVE;
      r_row       <= '0;
      r_col       <= '0;
      r_col_latch <= '1;
      r_row_drive <= ~ROWS'(1);
    end else begin
      case (r_state)
        ST_DRIVE: begin
          if (scan_tick) begin
            r_col_latch <= r_sync2;
            r_col       <= '0;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (int'(r_col) == COLS - 1) r_state <= ST_ADVANCE;
          else                         r_col   <= r_col + COL_W'(1);
        end
        ST_ADVANCE: begin
          r_row       <= w_row_next;
          r_row_drive <= ~(ROWS'(1) << w_row_next);
          r_state     <= ST_DRIVE;
        end
        default: r_state <= ST_DRIVE;
      endcase
    end
  end

  // Debounce: count consecutive disagreeing scans, commit only if queued
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the key-state arrays are reset explicitly because a mid-scan
    // reset must discard all partial debounce progress.
    if (!rst_n) begin
      r_stable <= '0;
      for (int k = 0; k < KEYS; k++) r_cnt[k] <= '0;
    end else if (w_in_scan) begin
      if (!w_differs) begin
        r_cnt[w_key] <= '0;
      end else if (!w_cnt_full) begin
        r_cnt[w_key] <= w_cnt + CNT_W'(1);
      end else if (w_push_ok) begin
        r_stable[w_key] <= w_raw;
        r_cnt[w_key]    <= '0;
      end
    end
  end

  // Event FIFO with modulo-depth pointers and an explicit occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_fifo[r_wr_ptr] <= '{pressed: w_raw, row: r_row, col: r_col};
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push_ok, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign w_head      = r_fifo[r_rd_ptr];
  assign row_drive   = r_row_drive;
  assign evt_valid   = (r_occ != '0);
  assign evt_pressed = w_head.pressed;
  assign evt_row     = w_head.row;
  assign evt_col     = w_head.col;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Randomised scoreboard bench for key_matrix_scanner: a per-key debounce
// model predicts the event stream at tick time; a monitor compares every
// handshake against it.
module tb_key_matrix_scanner;

  localparam int ROWS       = 8;
  localparam int COLS       = 8;
  localparam int DEBOUNCE   = 4;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic       pressed;
    logic [2:0] row;
    logic [2:0] col;
  } evt_t;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      scan_tick = 1'b0;
  logic                      evt_ready = 1'b0;
  logic [ROWS-1:0]           row_drive;
  logic [COLS-1:0]           col_sense;
  logic                      evt_valid;
  logic                      evt_pressed;
  logic [2:0]                evt_row;
  logic [2:0]                evt_col;
  logic [ROWS-1:0][COLS-1:0] keys = '0;

  evt_t sb[$];
  logic m_stable [ROWS][COLS];
  int   m_cnt    [ROWS][COLS];
  int   m_row;
  int   n_vec  = 0;
  int   n_miss = 0;
  evt_t mon_got;
  evt_t mon_exp;

  key_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_tick(scan_tick), .row_drive(row_drive),
    .col_sense(col_sense), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_pressed(evt_pressed), .evt_row(evt_row), .evt_col(evt_col)
  );

  always #5 clk = ~clk;

  // Ideal matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_sense = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_drive[r] && keys[r][c]) col_sense[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_stable[r][c] = 1'b0;
        m_cnt[r][c]    = 0;
      end
    m_row = 0;
    sb.delete();
  endtask

  // One row scan. rdy[0] is ready at the tick edge, rdy[c+1] at column c's edge.
  task automatic model_scan(input logic [COLS:0] rdy);
    int   occ;
    logic raw;
    bit   pop;
    bit   acc;
    occ = sb.size();
    if (rdy[0] && occ > 0) occ--;
    for (int c = 0; c < COLS; c++) begin
      raw = keys[m_row][c];
      pop = rdy[c+1] && (occ > 0);
      acc = 1'b0;
      if (raw == m_stable[m_row][c]) begin
        m_cnt[m_row][c] = 0;
      end else if (m_cnt[m_row][c] + 1 < DEBOUNCE) begin
        m_cnt[m_row][c]++;
      end else if (occ < FIFO_DEPTH || pop) begin
        sb.push_back(evt_t'{raw, 3'(m_row), 3'(c)});
        m_stable[m_row][c] = raw;
        m_cnt[m_row][c]    = 0;
        acc = 1'b1;
      end
      occ = occ + int'(acc) - int'(pop);
    end
  endtask

  task automatic quiescent();
    logic [ROWS-1:0] exp_rd;
    exp_rd = ~(ROWS'(1) << m_row);
    check("row_drive", 32'(row_drive), 32'(exp_rd));
    check("evt_valid", 32'(evt_valid), 32'(sb.size() != 0));
    if (sb.size() != 0)
      check("head", 32'({evt_pressed, evt_row, evt_col}), 32'(sb[0]));
  endtask

  task automatic do_tick(input logic [COLS:0] rdy, input logic rdy_after, input bit extra);
    repeat (3) @(posedge clk);
    #1;
    quiescent();
    evt_ready = rdy[0];
    scan_tick = 1'b1;
    model_scan(rdy);
    @(posedge clk); #1;
    scan_tick = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      evt_ready = rdy[c+1];
      if (extra && c == 2) scan_tick = 1'b1;
      @(posedge clk); #1;
      scan_tick = 1'b0;
    end
    evt_ready = rdy_after;
    if (extra) scan_tick = 1'b1;
    @(posedge clk); #1;
    scan_tick = 1'b0;
    m_row = (m_row + 1) % ROWS;
    repeat (6) @(posedge clk);
  endtask

  task automatic run_ticks(input int n, input logic [COLS:0] rdy, input logic rdy_after);
    for (int i = 0; i < n; i++) do_tick(rdy, rdy_after, 1'b0);
  endtask

  // Monitor: every accepted handshake must match the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && evt_valid && evt_ready) begin
        mon_got = {evt_pressed, evt_row, evt_col};
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_event: got %0h expected none at %0t", mon_got, $time);
        end else begin
          mon_exp = sb.pop_front();
          check("event", 32'(mon_got), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    logic [COLS:0] rdy;
    int            wait_cyc;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_drive", 32'(row_drive), 32'h00FE);
    check("rst_valid", 32'(evt_valid), 32'h0);
    check("rst_head", 32'({evt_pressed, evt_row, evt_col}), 32'h0);
    rst_n = 1'b1;

    // Row wrap with ignored extra ticks in SCAN and ADVANCE
    for (int i = 0; i < ROWS; i++) do_tick('1, 1'b1, 1'b1);
    check("wrap_row_drive", 32'(row_drive), 32'h00FE);

    // Single press then release of r2c5
    keys[2][5] = 1'b1;
    run_ticks(32, '1, 1'b1);
    keys[2][5] = 1'b0;
    run_ticks(32, '1, 1'b1);

    // Bounce: three low scans, one high, one low, then high
    keys[2][5] = 1'b1;
    run_ticks(24, '1, 1'b1);
    keys[2][5] = 1'b0;
    run_ticks(8, '1, 1'b1);
    keys[2][5] = 1'b1;
    run_ticks(8, '1, 1'b1);
    keys[2][5] = 1'b0;
    run_ticks(8, '1, 1'b1);

    // Backpressure: six presses into a four-entry queue
    keys[0][1] = 1'b1; keys[0][3] = 1'b1; keys[1][0] = 1'b1;
    keys[1][7] = 1'b1; keys[3][2] = 1'b1; keys[3][4] = 1'b1;
    run_ticks(40, '0, 1'b0);
    run_ticks(8, '1, 1'b1);
    keys = '0;
    run_ticks(32, '1, 1'b1);

    // Full queue with pop and push in the same cycle
    keys[4][1] = 1'b1; keys[4][2] = 1'b1; keys[4][3] = 1'b1;
    keys[4][4] = 1'b1; keys[5][0] = 1'b1;
    run_ticks(37, '0, 1'b0);
    do_tick(9'b0_0000_0010, 1'b0, 1'b0);
    do_tick('0, 1'b0, 1'b0);
    check("full_push_head_row", 32'(evt_row), 32'h4);
    check("full_push_head_col", 32'(evt_col), 32'h2);
    keys = '0;
    run_ticks(1, '1, 1'b1);
    run_ticks(32, '1, 1'b1);

    // Reset mid-scan with two events queued
    keys[0][1] = 1'b1; keys[0][3] = 1'b1;
    run_ticks(32, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    scan_tick = 1'b1;
    @(posedge clk); #1;
    scan_tick = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_row_drive", 32'(row_drive), 32'h00FE);
    check("midrst_valid", 32'(evt_valid), 32'h0);
    model_reset();
    @(posedge clk); #1;
    check("midrst_edge_row_drive", 32'(row_drive), 32'h00FE);
    check("midrst_edge_valid", 32'(evt_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_ticks(32, '1, 1'b1);
    keys = '0;
    run_ticks(32, '1, 1'b1);

    // Randomised keys and ready patterns
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(3) == 0)
        keys[$urandom_range(ROWS-1)][$urandom_range(COLS-1)] ^= 1'b1;
      case ($urandom_range(2))
        0:       rdy = '1;
        1:       rdy = '0;
        default: rdy = (COLS+1)'($urandom);
      endcase
      do_tick(rdy, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    keys = '0;
    run_ticks(40, '1, 1'b1);

    // Drain with a bounded wait
    evt_ready = 1'b1;
    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 100) begin
      @(posedge clk);
      wait_cyc++;
    end
    #1;
    check("drain_empty", 32'(sb.size()), 32'h0);
    check("drain_valid", 32'(evt_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
